// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative one-bit-per-cycle shifts,
// valid/ready handshake on request and result sides.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUop,
  input  logic               ALUsrcA,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               less,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   result_n, shreg, shreg_n, shstep;
  logic               zero_n, ovf_n, less_n, lessp, lessp_n;
  logic [SHAMT_W-1:0] cnt, cnt_n, amt;
  logic [1:0]         shop, shop_n;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf, lt, is_shift;

  assign sum      = A + B;
  assign diff     = A - B;
  assign lt       = $signed(A) < $signed(B);
  assign amt      = ALUsrcA ? shamt : A[SHAMT_W-1:0];
  assign is_shift = (ALUop == 4'b0100) || (ALUop == 4'b0101) || (ALUop == 4'b0110);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUop)
      4'b0000: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: alu_res = A | B;
      4'b0011: alu_res = A & B;
      4'b0100, 4'b0101, 4'b0110: alu_res = B;  // zero-distance shift passes B through
      4'b0111: alu_res = A ^ B;
      4'b1000: alu_res = ~(A | B);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (shop)
      2'b00:   shstep = {shreg[WIDTH-2:0], 1'b0};
      2'b01:   shstep = {1'b0, shreg[WIDTH-1:1]};
      default: shstep = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_n  = state;
    result_n = result;
    zero_n   = zero;
    ovf_n    = overflow;
    less_n   = less;
    shreg_n  = shreg;
    cnt_n    = cnt;
    shop_n   = shop;
    lessp_n  = lessp;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (amt != '0)) begin
            shreg_n = B;
            cnt_n   = amt;
            shop_n  = ALUop[1:0];
            lessp_n = lt;
            state_n = S_SHIFT;
          end else begin
            result_n = alu_res;
            zero_n   = (alu_res == '0);
            ovf_n    = alu_ovf;
            less_n   = lt;
            state_n  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        shreg_n = shstep;
        cnt_n   = cnt - 1'b1;
        // Last step: publish the freshly shifted value and the compare captured at accept
        if (cnt == SHAMT_W'(1)) begin
          result_n = shstep;
          zero_n   = (shstep == '0);
          ovf_n    = 1'b0;
          less_n   = lessp;
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      less     <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      shop     <= '0;
      lessp    <= 1'b0;
    end else begin
      state    <= state_n;
      result   <= result_n;
      zero     <= zero_n;
      overflow <= ovf_n;
      less     <= less_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      shop     <= shop_n;
      lessp    <= lessp_n;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued at issue, compared when out_valid rises.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ALUsrcA, out_valid, out_ready;
  logic [3:0]  ALUop;
  logic [31:0] A, B, result;
  logic [4:0]  shamt;
  logic        zero, overflow, less, busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        l;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .ALUsrcA(ALUsrcA), .A(A), .B(B), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .less(less), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic src, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t        e;
    logic [4:0]  n;
    logic [31:0] r;
    n = src ? sh : a[4:0];
    e.o = 1'b0;
    case (op)
      4'd0: begin r = a + b; e.o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; e.o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a | b;
      4'd3: r = a & b;
      4'd4: r = b << n;
      4'd5: r = b >> n;
      4'd6: r = $signed(b) >>> n;
      4'd7: r = a ^ b;
      4'd8: r = ~(a | b);
      default: r = 32'h0;
    endcase
    e.res = r;
    e.z   = (r == 32'h0);
    e.l   = $signed(a) < $signed(b);
    e.lat = ((op >= 4'd4) && (op <= 4'd6) && (n != 5'd0)) ? 32'(n) + 32'd1 : 32'd1;
    return e;
  endfunction

  // Returns just after the accepting edge.
  task automatic start_op(input logic [3:0] op, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    check("in_ready_before_issue", in_ready, 1);
    ALUop = op; ALUsrcA = src; A = a; B = b; shamt = sh; in_valid = 1'b1;
    sb.push_back(model(op, src, a, b, sh));
    @(posedge clk);
    #1 in_valid = 1'b0;
    A = $urandom; B = $urandom; shamt = 5'($urandom);
  endtask

  // Returns at the negedge where out_valid is seen.
  task automatic wait_result(input string tag);
    exp_t        e;
    int unsigned lat;
    bit          seen;
    lat  = 1;
    seen = 1'b0;
    e    = sb.pop_front();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check({tag, "_busy"}, {busy, in_ready}, 2'b10);
      @(posedge clk);
      lat++;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_result"}, result, e.res);
      check({tag, "_flags"}, {zero, overflow, less}, {e.z, e.o, e.l});
      check({tag, "_latency"}, lat, e.lat);
    end
  endtask

  task automatic collect(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check({tag, "_release"}, {out_valid, in_ready, busy}, 3'b010);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic src,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    start_op(op, src, a, b, sh);
    wait_result(tag);
    collect(tag);
  endtask

  initial begin
    logic [31:0] held;
    bit          spurious;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUop = '0; ALUsrcA = 1'b0; A = '0; B = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_ctrl", {out_valid, in_ready, busy, zero, overflow, less}, 6'b010000);

    run_op("add_ovf",   4'b0000, 1'b0, 32'h7FFFFFFF, 32'h1, 5'd0);
    run_op("sub_zero",  4'b0001, 1'b0, 32'd5, 32'd5, 5'd0);
    run_op("sub_neg",   4'b0001, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0);
    run_op("sra4",      4'b0110, 1'b1, 32'h0, 32'h80000000, 5'd4);
    run_op("srl4",      4'b0101, 1'b1, 32'h0, 32'h80000000, 5'd4);
    run_op("sllv",      4'b0100, 1'b0, 32'h00000123, 32'h1, 5'd0);
    run_op("sll0",      4'b0100, 1'b1, 32'hFFFFFFE0, 32'hDEADBEEF, 5'd0);
    run_op("sub_ovf",   4'b0001, 1'b0, 32'h80000000, 32'h1, 5'd0);
    run_op("sra31",     4'b0110, 1'b1, 32'h0, 32'h80000000, 5'd31);

    // Hold result in DONE while a competing request is presented
    start_op(4'b0000, 1'b0, 32'd3, 32'd4, 5'd0);
    wait_result("hold_add");
    held = 32'd7;
    in_valid = 1'b1; ALUop = 4'b0001; A = 32'd9; B = 32'd2;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_result", result, held);
      check("hold_ctrl", {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0;
    collect("hold");
    check("hold_no_accept", result, held);

    // Reset on the second shift cycle of a 31-bit shift aborts the op
    start_op(4'b0100, 1'b1, 32'h0, 32'h1, 5'd31);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    check("abort_result", result, 32'h0);
    check("abort_ctrl", {out_valid, in_ready, busy}, 3'b010);
    spurious = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    check("abort_no_valid", spurious, 0);

    run_op("nor",       4'b1000, 1'b0, 32'h0, 32'h0, 5'd0);
    run_op("undef1010", 4'b1010, 1'b0, 32'h12345678, 32'h9ABCDEF0, 5'd0);
    run_op("xor",       4'b0111, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
    run_op("and",       4'b0011, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
    run_op("or",        4'b0010, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), 1'($urandom), $urandom, $urandom, 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU of the pipeline. It consumes the 4-bit ALUop and ALUsrcA produced by the funct decoder, operates on two register operands and returns a registered result plus flags.
- Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, to keep the barrel shifter off the critical path.
- Valid/ready handshake on both sides so the pipeline controller can stall around multi-cycle shifts.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- ALUop  input  4  operation code.
- ALUsrcA  input  1  1: shift amount from shamt; 0: shift amount from A[SHAMT_W-1:0].
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt/imm); also the shifted operand.
- shamt  input  SHAMT_W  instruction shift-amount field.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow of add/sub.
- less  output  1  signed A < B; for slt, consumer selects this.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- On rst: state=IDLE, result=0, zero=0, overflow=0, less=0, out_valid=0, shift counter=0. in_ready=1 from the first cycle after reset. A rst mid-shift or in DONE aborts the operation; no out_valid follows.
- ALUop encoding:
  - 0000 add A+B
  - 0001 sub A-B
  - 0010 or
  - 0011 and
  - 0100 sll B
  - 0101 srl B
  - 0110 sra B
  - 0111 xor
  - 1000 nor
  - 1001..1111: result=0, overflow=0.
- Arithmetic is modulo 2^WIDTH.
  - overflow, add: sign(A)==sign(B) and sign(sum)!=sign(A).
  - overflow, sub: sign(A)!=sign(B) and sign(diff)!=sign(A).
  - overflow=0 for all other ops.
- less = signed comparison of A<B, computed for every op and captured at accept.
- Shift amount N = ALUsrcA ? shamt : A[SHAMT_W-1:0]. Upper bits of A are ignored.
- IDLE: in_ready=1, busy=0. Accept when in_valid && in_ready at a rising edge (T0).
  - Non-shift op, or shift with N=0: result/zero/overflow/less registered at T0, go to DONE. Latency is 1 cycle.
  - Shift with N>0: load shift register=B, counter=N, go to SHIFT.
- SHIFT: in_ready=0, busy=1. Each edge shifts the register by one bit and decrements the counter.
  - sll fills 0; srl fills 0; sra fills the MSB.
  - When the counter reaches 0 at an edge, result=shift register and flags are updated in the same edge; go to DONE. out_valid is visible after edge T0+N, a latency of N+1 cycles.
  - The operand inputs are don't-care after T0.
- DONE: out_valid=1, in_ready=0. result and flags are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE and clear out_valid.
  - No new request is accepted in the same cycle, so the minimum issue interval is 2 cycles.
- result, zero, overflow and less keep their last values in IDLE. Only out_valid qualifies them.
- in_valid while in_ready=0 is ignored; the requester must hold it.

Test Plan:
- Reset, then add A=0x7FFFFFFF, B=1 -> after 1 cycle out_valid=1, result=0x80000000, overflow=1, zero=0, less=0.
- sub A=5, B=5 -> result=0, zero=1, overflow=0. sub A=0xFFFFFFFF (-1), B=1 -> result=0xFFFFFFFE, less=1.
- sra B=0x80000000, ALUsrcA=1, shamt=4 -> busy for 4 cycles, out_valid on cycle 5, result=0xF8000000. srl with the same inputs -> result=0x08000000.
- sllv with A=0x00000123 (N=0x03), B=1, ALUsrcA=0 -> result=0x8, latency 4. sll with shamt=0 -> latency 1, result=B.
- Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> IDLE next cycle.
- Assert rst on the 2nd SHIFT cycle of a 31-bit shift -> next cycle state IDLE, result=0, out_valid=0, in_ready=1. A subsequent nor A=0, B=0 -> result=0xFFFFFFFF. ALUop=1010 -> result=0, zero=1.
